// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU and its memory-side responder.
// Holds bus geometry, the opcode map and the responder state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W    = 5;
  localparam int CPU_DATA_W    = 8;
  localparam int CPU_TRAP_ADDR = 31;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_STO = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_JNZ = 3'd5;
  localparam logic [2:0] OP_JNC = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } rsp_state_e;

endpackage

// File: rtl/mem_array_32x8.sv
// Unified instruction/data register file: one synchronous write port,
// one asynchronous read port, every word cleared by reset.
module mem_array_32x8 #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: this store is built from flops, not a RAM macro, so it can and must
  // be cleared on reset; a RAM-backed store would instead need an init sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU MA/MD bus: req/ack handshake with
// programmable wait states, loader preload port and trap-word detection.
module cpu_mem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = CPU_ADDR_W,
  parameter int DATA_W    = CPU_DATA_W,
  parameter int WAIT      = 1,
  parameter int TRAP_ADDR = CPU_TRAP_ADDR
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              trap,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  rsp_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  mem_array_32x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clock  (clock),
    .reset_n(reset_n),
    .wr_en  (mem_we),
    .wr_addr(mem_waddr),
    .wr_data(mem_wdata),
    .rd_addr(mem_raddr),
    .rd_data(mem_rdata)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    mem_raddr = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          mem_we = 1'b1;
        end else if (req) begin
          addr_d    = addr;
          we_d      = we;
          wdata_d   = wdata;
          cnt_d     = WAIT_CNT;
          mem_raddr = addr;
          // With no wait states the read data must be captured straight from the bus address.
          if (WAIT == 0) begin
            state_d = ST_RESP;
            if (!we) rdata_d = mem_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RESP;
          if (!we_q) rdata_d = mem_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = wdata_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack        = (state_q == ST_RESP);
  assign trap       = ack && !we_q && (addr_q == ADDR_W'(TRAP_ADDR));
  assign rdata      = rdata_q;
  assign load_ready = (state_q == ST_IDLE);

endmodule
